// File: rtl/st_timing_adapter_fifo.sv
// st_timing_adapter_fifo: single-clock first-word-fall-through buffer that absorbs
// timing differences between a non-backpressurable source and a ready/valid sink.
// Words arriving while the buffer is full (and not being drained) are dropped
// and recorded in a sticky overflow flag.
module st_timing_adapter_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [CW-1:0]         fill_level,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // Handshake decode: a pop frees a slot, so a full buffer still accepts a word
    // when it is drained in the same cycle.
    always_comb begin
        full      = (count == CW'(DEPTH));
        out_valid = (count != '0);
        pop       = out_valid && out_ready;
        push      = in_valid && (!full || pop);
        drop      = in_valid && full && !pop;
    end

    assign out_data   = storage[rd_ptr];
    assign fill_level = count;

    // Payload storage; intentionally not reset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            storage[wr_ptr] <= in_data;
        end
    end

    // Pointers and fill count; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    // Report each dropped word in simulation.
    always @(posedge clk) begin
        if (!reset && drop) begin
            $display("st_timing_adapter_fifo: buffer full, word 0x%0h dropped at %0t", in_data, $time);
        end
    end
`endif

endmodule

// File: tb/tb_st_timing_adapter_fifo.sv
// Directed testbench for st_timing_adapter_fifo (DATA_WIDTH=8, DEPTH=4).
module tb_st_timing_adapter_fifo;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [CW-1:0] fill_level;
    logic          overflow;
    logic          overflow_clr;

    int unsigned errors = 0;
    int unsigned checks = 0;

    st_timing_adapter_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH(DP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .fill_level(fill_level),
        .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_a0();
        out_ready = 1'b0;
        for (int i = 0; i < DP; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; overflow_clr = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_pass_through();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                errors++; $display("FAIL pass_data got=%b/%h exp=1/%h", out_valid, out_data, 8'(i));
            end
            checks++; if (fill_level !== 3'd1) begin errors++; $display("FAIL pass_fill got=%0d exp=1", fill_level); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (fill_level !== 3'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL pass_end got fill=%0d ovf=%b exp fill=0 ovf=0", fill_level, overflow);
        end
    endtask

    task automatic test_fill_drain();
        fill_a0();
        checks++; if (fill_level !== 3'd4 || out_data !== 8'hA0) begin
            errors++; $display("FAIL fill_full got fill=%0d data=%h exp fill=4 data=a0", fill_level, out_data);
        end
        out_ready = 1'b1;
        for (int k = 0; k < DP; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0 + 8'(k) || fill_level !== 3'(DP - k)) begin
                errors++; $display("FAIL drain_%0d got v=%b data=%h fill=%0d exp v=1 data=%h fill=%0d",
                                   k, out_valid, out_data, fill_level, 8'hA0 + 8'(k), DP - k);
            end
            step();
        end
        checks++; if (out_valid !== 1'b0 || fill_level !== 3'd0) begin
            errors++; $display("FAIL drain_empty got v=%b fill=%0d exp v=0 fill=0", out_valid, fill_level);
        end
        // Ready while empty must not underflow the count.
        step();
        checks++; if (fill_level !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL ready_empty got v=%b fill=%0d exp v=0 fill=0", out_valid, fill_level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        fill_a0();
        in_valid = 1'b1; in_data = 8'hB0;
        step();
        checks++; if (overflow !== 1'b1 || fill_level !== 3'd4) begin
            errors++; $display("FAIL ovf_set got ovf=%b fill=%0d exp ovf=1 fill=4", overflow, fill_level);
        end
        // Drop coinciding with clear keeps the flag set.
        overflow_clr = 1'b1; in_data = 8'hB1;
        step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_race got=%b exp=1", overflow); end
        in_valid = 1'b0;
        step();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        overflow_clr = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < DP; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0 + 8'(k)) begin
                errors++; $display("FAIL ovf_drain_%0d got v=%b data=%h exp v=1 data=%h", k, out_valid, out_data, 8'hA0 + 8'(k));
            end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_empty got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp_seq [4];
        exp_seq[0] = 8'hA1; exp_seq[1] = 8'hA2; exp_seq[2] = 8'hA3; exp_seq[3] = 8'hC0;
        fill_a0();
        in_valid = 1'b1; in_data = 8'hC0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (fill_level !== 3'd4 || overflow !== 1'b0) begin
            errors++; $display("FAIL full_pp got fill=%0d ovf=%b exp fill=4 ovf=0", fill_level, overflow);
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[k]) begin
                errors++; $display("FAIL full_pp_drain_%0d got v=%b data=%h exp v=1 data=%h", k, out_valid, out_data, exp_seq[k]);
            end
            step();
        end
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL full_pp_empty got=%0d exp=0", fill_level); end
        out_ready = 1'b0;
    endtask

    task automatic test_empty_push_ready();
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (fill_level !== 3'd1 || out_valid !== 1'b1 || out_data !== 8'h55) begin
            errors++; $display("FAIL empty_pr got fill=%0d v=%b data=%h exp fill=1 v=1 data=55", fill_level, out_valid, out_data);
        end
        step();
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL empty_pr_pop got=%0d exp=0", fill_level); end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] q [$];
        int unsigned sent = 0;
        int unsigned recvd = 0;
        int unsigned cyc = 0;
        logic do_pop;
        logic do_push;
        while ((sent < 10 || q.size() != 0) && cyc < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            do_pop    = out_ready && (q.size() != 0);
            do_push   = (sent < 10) && (q.size() < DP || do_pop);
            in_valid  = do_push;
            in_data   = 8'h30 + 8'(sent);
            checks++; if (out_valid !== (q.size() != 0) || fill_level !== 3'(q.size())) begin
                errors++; $display("FAIL wrap_state got v=%b fill=%0d exp fill=%0d", out_valid, fill_level, q.size());
            end
            if (q.size() != 0) begin
                checks++; if (out_data !== q[0]) begin
                    errors++; $display("FAIL wrap_data got=%h exp=%h", out_data, q[0]);
                end
            end
            step();
            if (do_pop) begin void'(q.pop_front()); recvd++; end
            if (do_push) begin q.push_back(in_data); sent++; end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (recvd != 10) begin errors++; $display("FAIL wrap_count got=%0d exp=10 (cycles=%0d)", recvd, cyc); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'hE0 + 8'(i);
            step();
        end
        reset = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || fill_level !== 3'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL mid_reset got v=%b fill=%0d ovf=%b exp 0/0/0", out_valid, fill_level, overflow);
        end
        in_valid = 1'b1; in_data = 8'hD0;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hD0 || fill_level !== 3'd1) begin
            errors++; $display("FAIL mid_reset_first got v=%b data=%h fill=%0d exp v=1 data=d0 fill=1", out_valid, out_data, fill_level);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_empty_push_ready();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
